image_decimate: RTL

- Streaming power-of-two image decimator for the SIFT pyramid path.
- Accepts raster-ordered pixels tagged with (x,y) coordinates, for example from the UART image collector.
- Emits a reduced image as linear-addressed writes into a frame buffer BRAM.
- Generalises the fixed 2x halver: runtime-selectable decimation mode, parametrised factor/size, frame-level state machine with completion flag.

---
 rtl/image_decimate.sv | 107 ++++++++++
 1 files changed

// File: rtl/image_decimate.sv
// Streaming power-of-two image decimator: subsample or box-average blocks of raster pixels into linear frame-buffer writes.
// Optional IMG_DECIMATE_ROUND_EN: box mode rounds half up (with saturation) instead of truncating.
module image_decimate #(
  parameter int BIT_DEPTH   = 8,
  parameter int WIDTH       = 64,
  parameter int HEIGHT      = 64,
  parameter int FACTOR_LOG2 = 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      mode_in,
  input  logic [BIT_DEPTH-1:0]      data_in,
  input  logic [$clog2(WIDTH)-1:0]  data_x_in,
  input  logic [$clog2(HEIGHT)-1:0] data_y_in,
  input  logic                      data_valid_in,
  output logic [BIT_DEPTH-1:0]      data_out,
  output logic [$clog2((WIDTH>>FACTOR_LOG2)*(HEIGHT>>FACTOR_LOG2))-1:0] data_addr_out,
  output logic                      data_valid_out,
  output logic                      done_out
);
  localparam int F   = FACTOR_LOG2;
  localparam int NW  = WIDTH >> F;
  localparam int NH  = HEIGHT >> F;
  localparam int XW  = $clog2(WIDTH);
  localparam int YW  = $clog2(HEIGHT);
  localparam int AD  = $clog2(NW*NH);
  localparam int AW  = BIT_DEPTH + 2*F;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state;
  logic   frame_mode;

  logic [AW-1:0]        acc [NW];
  logic [F-1:0]         lx, ly;
  logic [XW-F-1:0]      bx;
  logic [YW-F-1:0]      by;
  logic                 in_range, origin, frame_last, blk_first, blk_last;
  logic                 accept, mode_eff;
  logic [AW-1:0]        sum;
  logic [BIT_DEPTH-1:0] box_pix;
  logic [AD-1:0]        blk_addr;

  assign lx         = data_x_in[F-1:0];
  assign ly         = data_y_in[F-1:0];
  assign bx         = data_x_in[XW-1:F];
  assign by         = data_y_in[YW-1:F];
  assign in_range   = (int'(data_x_in) < WIDTH) && (int'(data_y_in) < HEIGHT);
  assign origin     = (data_x_in == '0) && (data_y_in == '0);
  assign frame_last = (int'(data_x_in) == WIDTH-1) && (int'(data_y_in) == HEIGHT-1);
  assign blk_first  = (lx == '0) && (ly == '0);
  assign blk_last   = (&lx) && (&ly);
  // Outside a frame only the origin pixel is accepted, so it may use mode_in directly.
  assign accept     = data_valid_in && in_range && (state == ACTIVE || origin);
  assign mode_eff   = (state == ACTIVE) ? frame_mode : mode_in;
  assign sum        = acc[bx] + AW'(data_in);
  assign blk_addr   = AD'(by) * AD'(NW) + AD'(bx);

`ifdef IMG_DECIMATE_ROUND_EN
  localparam logic [AW:0] HALF = (AW+1)'(1) << (2*F-1);
  localparam logic [AW:0] MAXV = (AW+1)'((1 << BIT_DEPTH) - 1);
  logic [AW:0] rnd;
  assign rnd     = ({1'b0, sum} + HALF) >> (2*F);
  assign box_pix = (rnd > MAXV) ? '1 : rnd[BIT_DEPTH-1:0];
`else
  assign box_pix = sum[AW-1:2*F];
`endif

  // Accumulators carry no reset; the first pixel of each block overwrites them.
  always_ff @(posedge clk_in) begin
    if (!rst_in && accept && mode_eff)
      acc[bx] <= blk_first ? AW'(data_in) : sum;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      frame_mode     <= 1'b0;
      data_out       <= '0;
      data_addr_out  <= '0;
      data_valid_out <= 1'b0;
      done_out       <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      if (accept) begin
        if (state != ACTIVE) begin
          frame_mode <= mode_in;
          done_out   <= 1'b0;
        end
        if (frame_last) begin
          state    <= DONE;
          done_out <= 1'b1;
        end else begin
          state <= ACTIVE;
        end
        if (mode_eff && blk_last) begin
          data_out       <= box_pix;
          data_addr_out  <= blk_addr;
          data_valid_out <= 1'b1;
        end else if (!mode_eff && blk_first) begin
          data_out       <= data_in;
          data_addr_out  <= blk_addr;
          data_valid_out <= 1'b1;
        end
      end
    end
  end
endmodule
